// File: rtl/inst_trace_buf.sv
// inst_trace_buf: captures {PC, instruction, sequence tag} records from a
// multicycle CPU on each fetch->decode transition and queues them in a FIFO.
//
// Ports:
//   clk, rst        single clock, asynchronous active-high reset
//   S               CPU state (0 = fetch, 1 = decode)
//   addr, inst      CPU address / read data (PC and instruction while S==0)
//   trace_en        capture enable, sampled in the decode cycle
//   clr             synchronous flush of FIFO, flags and counters
//   rd_ready        consumer accepts the head record
//   rd_valid        head record available
//   rd_pc/rd_inst/rd_seq  head record fields (combinational from storage)
//   count           occupied entries
//   ovf             sticky overflow flag
//   drop_cnt        saturating dropped-record counter
module inst_trace_buf #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               S,
    input  logic [31:0]              addr,
    input  logic [31:0]              inst,
    input  logic                     trace_en,
    input  logic                     clr,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [31:0]              rd_pc,
    output logic [31:0]              rd_inst,
    output logic [7:0]               rd_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = 72;

    logic [RW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_q, drop_d;
    logic [7:0]    seq_q, seq_d;
    logic [31:0]   pc_hold_q, pc_hold_d;
    logic [31:0]   inst_hold_q, inst_hold_d;
    logic [3:0]    prev_s_q;

    logic push_req, full, pop, wr_en, drop;

    // Push request on the first decode cycle after a fetch; reset leaves
    // prev_s_q at a non-fetch value so no push happens before a real fetch.
    assign push_req = (S == 4'd1) && (prev_s_q == 4'd0) && trace_en;
    assign full     = (count_q == CW'(DEPTH));
    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid && rd_ready && !clr;
    // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
    assign wr_en    = push_req && !clr && (!full || pop);
    assign drop     = push_req && !clr && full && !pop;

    // Next-state logic
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        drop_d      = drop_q;
        seq_d       = seq_q;
        pc_hold_d   = pc_hold_q;
        inst_hold_d = inst_hold_q;

        // Fetch-cycle latch runs regardless of trace_en or clr.
        if (S == 4'd0) begin
            pc_hold_d   = addr;
            inst_hold_d = inst;
        end

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            drop_d   = '0;
            seq_d    = '0;
        end else begin
            if (push_req) seq_d = seq_q + 8'd1;
            if (wr_en)    wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_en, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= '0;
            seq_q       <= '0;
            pc_hold_q   <= '0;
            inst_hold_q <= '0;
            prev_s_q    <= 4'd15;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
            seq_q       <= seq_d;
            pc_hold_q   <= pc_hold_d;
            inst_hold_q <= inst_hold_d;
            prev_s_q    <= S;
        end
    end

    // Record storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {pc_hold_q, inst_hold_q, seq_q};
    end

    assign rd_pc    = mem_q[rd_ptr_q][71:40];
    assign rd_inst  = mem_q[rd_ptr_q][39:8];
    assign rd_seq   = mem_q[rd_ptr_q][7:0];
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_inst_trace_buf.sv
// Testbench for inst_trace_buf: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_inst_trace_buf;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  S = 4'd2;
    logic [31:0] addr = '0;
    logic [31:0] inst = '0;
    logic        trace_en = 1'b0;
    logic        clr = 1'b0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_pc, rd_inst;
    logic [7:0]  rd_seq;
    logic [4:0]  count;
    logic        ovf;
    logic [7:0]  drop_cnt;

    inst_trace_buf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .S(S), .addr(addr), .inst(inst),
        .trace_en(trace_en), .clr(clr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_inst(rd_inst),
        .rd_seq(rd_seq), .count(count), .ovf(ovf), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [7:0]  seq;
    } rec_t;

    rec_t        q[$];
    logic [3:0]  m_prev = 4'd15;
    logic [31:0] m_pc = '0, m_inst = '0;
    logic [7:0]  m_seq = '0, m_drop = '0;
    logic        m_ovf = 1'b0;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("count", 32'(count), 32'(q.size()));
        chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (q.size() != 0) begin
            chk("rd_pc", rd_pc, q[0].pc);
            chk("rd_inst", rd_inst, q[0].ins);
            chk("rd_seq", 32'(rd_seq), 32'(q[0].seq));
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input logic [3:0] s, input logic [31:0] a, input logic [31:0] i,
                        input logic te, input logic c, input logic rr);
        logic push, pop;
        rec_t r;
        S = s; addr = a; inst = i; trace_en = te; clr = c; rd_ready = rr;
        push = (s == 4'd1) && (m_prev == 4'd0) && te;
        pop  = (q.size() != 0) && rr;
        @(posedge clk);
        #1;
        if (c) begin
            q.delete();
            m_ovf = 1'b0; m_drop = '0; m_seq = '0;
        end else begin
            if (pop) r = q.pop_front();
            if (push) begin
                if (q.size() < int'(DEPTH)) begin
                    r.pc = m_pc; r.ins = m_inst; r.seq = m_seq;
                    q.push_back(r);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                end
                m_seq = m_seq + 8'd1;
            end
        end
        if (s == 4'd0) begin
            m_pc = a; m_inst = i;
        end
        m_prev = s;
        check_state();
    endtask

    task automatic pair(input logic te, input logic rr);
        step(4'd0, $urandom, $urandom, te, 1'b0, 1'b0);
        step(4'd1, $urandom, $urandom, te, 1'b0, rr);
    endtask

    task automatic model_reset();
        q.delete();
        m_prev = 4'd15; m_pc = '0; m_inst = '0;
        m_seq = '0; m_drop = '0; m_ovf = 1'b0;
    endtask

    initial begin
        // Power-on reset
        #12;
        chk("reset_valid", 32'(rd_valid), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;

        // Decode before any fetch after reset must not push
        step(4'd1, 32'h1234, 32'h5678, 1'b1, 1'b0, 1'b0);

        // Single capture
        step(4'd0, 32'h0000_0040, 32'h2008_0005, 1'b1, 1'b0, 1'b0);
        step(4'd1, 32'hDEAD_0000, 32'hBEEF_0000, 1'b1, 1'b0, 1'b0);
        chk("cap_valid", 32'(rd_valid), 32'd1);
        chk("cap_pc", rd_pc, 32'h0000_0040);
        chk("cap_inst", rd_inst, 32'h2008_0005);
        chk("cap_seq", 32'(rd_seq), 32'd0);
        chk("cap_count", 32'(count), 32'd1);

        // Fill and overflow
        step(4'd2, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 18; k++) pair(1'b1, 1'b0);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_ovf", 32'(ovf), 32'd1);
        chk("fill_drop", 32'(drop_cnt), 32'd2);
        chk("fill_head", 32'(rd_seq), 32'd0);

        // Full with simultaneous push and pop
        pair(1'b1, 1'b1);
        chk("pp_count", 32'(count), 32'd16);
        chk("pp_ovf", 32'(ovf), 32'd1);
        chk("pp_drop", 32'(drop_cnt), 32'd2);
        chk("pp_tail", 32'(q[15].seq), 32'd18);

        // Drain
        for (int k = 0; k < 16; k++) step(4'd2, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("drain_valid", 32'(rd_valid), 32'd0);
        step(4'd2, '0, '0, 1'b0, 1'b0, 1'b1);

        // Gating
        step(4'd2, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) pair(1'b0, 1'b0);
        pair(1'b1, 1'b0);
        chk("gate_count", 32'(count), 32'd1);
        chk("gate_seq", 32'(rd_seq), 32'd0);

        // trace_en sampled in the decode cycle
        step(4'd0, 32'hA0, 32'hA1, 1'b1, 1'b0, 1'b0);
        step(4'd1, '0, '0, 1'b0, 1'b0, 1'b0);
        step(4'd0, 32'hB0, 32'hB1, 1'b0, 1'b0, 1'b0);
        step(4'd1, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("te_count", 32'(count), 32'd2);

        // clr with count=5 and ovf set
        step(4'd2, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 17; k++) pair(1'b1, 1'b0);
        for (int k = 0; k < 11; k++) step(4'd2, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("pre_clr_count", 32'(count), 32'd5);
        chk("pre_clr_ovf", 32'(ovf), 32'd1);
        step(4'd1, '0, '0, 1'b1, 1'b1, 1'b1);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);

        // Asynchronous reset mid-operation
        for (int k = 0; k < 4; k++) pair(1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(rd_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        model_reset();
        #2 rst = 1'b0;
        step(4'd1, 32'h77, 32'h88, 1'b1, 1'b0, 1'b0);
        chk("arst_nopush", 32'(count), 32'd0);
        pair(1'b1, 1'b0);
        chk("arst_first_seq", 32'(rd_seq), 32'd0);

        // Random traffic, slow consumer then balanced
        for (int k = 0; k < 500; k++) begin
            logic rr;
            rr = (k < 250) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
            step(4'($urandom_range(0, 3)), $urandom, $urandom,
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 59) == 0), rr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
